// File: rtl/sub_sched_pkg.sv
// Shared constants, widths and the requester tag type for the subtract scheduler.
package sub_sched_pkg;

    localparam int ELEM_W          = 48;   // packed operand: two float lanes
    localparam int LANE_W          = 24;   // one float lane
    localparam int DEF_NREQ        = 4;
    localparam int DEF_SUB_LATENCY = 5;
    localparam int DEF_MAX_OUT     = 2;

    // Requester id width; a single requester still gets a 1-bit id.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(DEF_NREQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/sub_sched_if.sv
// Requester-side request/response bundle of the subtract scheduler.
interface sub_sched_if
    import sub_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
);
    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ELEM_W-1:0] req_a;
    logic [NREQ*ELEM_W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [ELEM_W-1:0]      rsp_data;

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

    // Requester side.
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/sub_sched_chk.sv
// Outstanding-counter invariants of the subtract scheduler.
module sub_sched_chk #(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 2
) (
    input logic                  clock,
    input logic                  reset,
    input logic [NREQ*CNT_W-1:0] cnt,
    input logic [NREQ-1:0]       inc,
    input logic [NREQ-1:0]       dec
);

    logic [NREQ-1:0]       both_r;
    logic [NREQ*CNT_W-1:0] cnt_prev_r;

    // Remember last cycle's counters and accept-plus-response coincidences.
    always_ff @(posedge clock) begin
        if (reset) begin
            both_r     <= '0;
            cnt_prev_r <= '0;
        end else begin
            both_r     <= inc & dec;
            cnt_prev_r <= cnt;
        end
    end

    // Counter bounds and the hold-on-coincidence rule.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                assert (!(dec[i] && !inc[i] && cnt[i*CNT_W +: CNT_W] == '0))
                    else $error("outstanding counter underflow on requester %0d", i);
                assert (int'(cnt[i*CNT_W +: CNT_W]) <= MAX_OUT)
                    else $error("outstanding counter above limit on requester %0d", i);
                assert (!both_r[i] || cnt[i*CNT_W +: CNT_W] == cnt_prev_r[i*CNT_W +: CNT_W])
                    else $error("counter moved on accept+response, requester %0d", i);
            end
        end
    end

endmodule

// File: rtl/sub_sched_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or after ptr, wrapping.
module rr_arbiter
    import sub_sched_pkg::*;
#(
    parameter int N  = DEF_NREQ,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    // Rotating priority search starting at ptr.
    always_comb begin
        int unsigned j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!grant_any && eligible[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/sub_sched.sv
// Round-robin scheduler sharing one pipelined subtract datapath between requesters.
module sub_sched
    import sub_sched_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int SUB_LATENCY = DEF_SUB_LATENCY,
    parameter int MAX_OUT     = DEF_MAX_OUT
) (
    input  logic              clock,
    input  logic              reset,
    sub_sched_if.slave        bus,
    input  logic              hold,
    output logic [ELEM_W-1:0] sub_a,
    output logic [ELEM_W-1:0] sub_b,
    input  logic [ELEM_W-1:0] sub_result,
    output logic              busy
);

    localparam int IDW   = id_w(NREQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    // Tag sized for this instance's requester count.
    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } pipe_tag_t;

    logic [NREQ-1:0]        elig_s;
    logic [NREQ-1:0]        dec_s;
    logic [NREQ-1:0]        grant_s;
    logic [IDW-1:0]         idx_s;
    logic                   any_s;
    logic [IDW-1:0]         ptr_r;
    logic [CNT_W-1:0]       cnt_r [NREQ];
    logic [NREQ*CNT_W-1:0]  cnt_flat_s;
    pipe_tag_t              tag_r [SUB_LATENCY];
    logic                   rsp_valid_r;
    logic [IDW-1:0]         rsp_id_r;
    logic [ELEM_W-1:0]      rsp_data_r;
    logic                   busy_s;

    // Eligibility per requester and response-driven credit returns.
    always_comb begin
        elig_s = '0;
        dec_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = bus.req_valid[i] & ~hold & ~reset & (cnt_r[i] < CNT_W'(MAX_OUT));
            dec_s[i]  = rsp_valid_r & (rsp_id_r == IDW'(i));
        end
    end

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .eligible  (elig_s),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (idx_s),
        .grant_any (any_s)
    );

    assign bus.req_ready = grant_s;

    // Steer the granted operands into the datapath; zeros when idle.
    always_comb begin
        if (any_s) begin
            sub_a = bus.req_a[int'(idx_s)*ELEM_W +: ELEM_W];
            sub_b = bus.req_b[int'(idx_s)*ELEM_W +: ELEM_W];
        end else begin
            sub_a = '0;
            sub_b = '0;
        end
    end

    // Round-robin pointer advances past the requester just granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (any_s) begin
            ptr_r <= (idx_s == IDW'(NREQ - 1)) ? '0 : idx_s + IDW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag pipe tracks the datapath stage by stage; it never stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SUB_LATENCY; k++) tag_r[k] <= '0;
        end else begin
            tag_r[0] <= '{vld: any_s, id: (any_s ? idx_s : '0)};
            for (int k = 1; k < SUB_LATENCY; k++) tag_r[k] <= tag_r[k-1];
        end
    end

    // Response register; data only reloads when a valid tag emerges.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
        end else begin
            rsp_valid_r <= tag_r[SUB_LATENCY-1].vld;
            rsp_id_r    <= tag_r[SUB_LATENCY-1].id;
            rsp_data_r  <= tag_r[SUB_LATENCY-1].vld ? sub_result : rsp_data_r;
        end
    end

    // Per-requester outstanding counters; accept and return together cancel.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({grant_s[i], dec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Anything in the pipe or in the response register keeps busy high.
    always_comb begin
        busy_s     = rsp_valid_r;
        cnt_flat_s = '0;
        for (int k = 0; k < SUB_LATENCY; k++) busy_s = busy_s | tag_r[k].vld;
        for (int i = 0; i < NREQ; i++) cnt_flat_s[i*CNT_W +: CNT_W] = cnt_r[i];
    end

    assign busy          = busy_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_data  = rsp_data_r;

    sub_sched_chk #(.NREQ(NREQ), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_chk (
        .clock (clock),
        .reset (reset),
        .cnt   (cnt_flat_s),
        .inc   (grant_s),
        .dec   (dec_s)
    );

endmodule

// File: tb/tb_sub_sched.sv
// Scoreboard bench for sub_sched with an XOR stub datapath.
module tb_sub_sched;
    import sub_sched_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 5;
    localparam int MO  = 2;

    typedef struct {
        logic [1:0]  id;
        logic [47:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hold  = 1'b0;
    logic [47:0] sub_a, sub_b, sub_result;
    logic        busy;
    logic [47:0] dp [LAT];

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    sub_sched_if #(.NREQ(N)) bus ();

    sub_sched #(.NREQ(N), .SUB_LATENCY(LAT), .MAX_OUT(MO)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .hold       (hold),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_result (sub_result),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Stub datapath: LAT-stage delay of a ^ b, no reset.
    always @(posedge clock) begin
        dp[0] <= sub_a ^ sub_b;
        for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
    end
    assign sub_result = dp[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 40 && busy; n++) @(negedge clock);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: compare responses, then record acceptances or flush on reset.
    always @(negedge clock) begin
        exp_t e;
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            end
        end
        if (reset) begin
            sb.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    e.id   = 2'(i);
                    e.data = bus.req_a[i*48 +: 48] ^ bus.req_b[i*48 +: 48];
                    sb.push_back(e);
                end
            end
        end
    end

    // Time bound for the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] credit_exp;
        credit_exp    = 15'b100000110000011;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*48 +: 48] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            bus.req_b[i*48 +: 48] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        end

        // Reset state, with requests already pending.
        tick(); tick();
        @(negedge clock);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

        // Contention: all four valid from reset release.
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("contend_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            for (int i = 0; i < N; i++) bus.req_a[i*48 +: 48] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        end
        bus.req_valid = 4'b0000;
        drain("contend");

        // Single request from requester 2.
        tick();
        bus.req_valid = 4'b0100;
        bus.req_a[2*48 +: 48] = 48'h000001_000003;
        bus.req_b[2*48 +: 48] = 48'h000002_000001;
        @(negedge clock);
        chk("single_ready", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        bus.req_valid = 4'b0000;
        repeat (4) tick();
        @(negedge clock);
        chk("single_early", 64'(bus.rsp_valid), 64'd0);
        tick();
        @(negedge clock);
        chk("single_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_id", 64'(bus.rsp_id), 64'd2);
        chk("single_data", 64'(bus.rsp_data), 64'h000003_000002);
        drain("single");

        // Credit limit: requester 1 alone, continuously.
        tick();
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            chk("credit_ready", 64'(bus.req_ready), 64'({2'b00, credit_exp[k], 1'b0}));
            tick();
            bus.req_a[1*48 +: 48] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        end
        bus.req_valid = 4'b0000;
        drain("credit");

        // hold: two grants, then block while the pipe drains, then resume.
        tick();
        bus.req_valid = 4'b1011;
        @(negedge clock);
        chk("hold_pre0", 64'(bus.req_ready), 64'(4'b1000));
        tick();
        @(negedge clock);
        chk("hold_pre1", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("hold_ready", 64'(bus.req_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        drain("hold");
        chk("hold_ready_idle", 64'(bus.req_ready), 64'd0);
        tick();
        hold = 1'b0;
        @(negedge clock);
        chk("hold_resume0", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        @(negedge clock);
        chk("hold_resume1", 64'(bus.req_ready), 64'(4'b1000));
        tick();
        bus.req_valid = 4'b0000;
        drain("hold_tail");

        // Reset mid-flight: three ops, reset two cycles after the last.
        tick();
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("rmf_grant", 64'(bus.req_ready), 64'(4'b0001 << k));
            tick();
        end
        bus.req_valid = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_valid = 4'b1000;
        bus.req_a[3*48 +: 48] = 48'h123456_789ABC;
        bus.req_b[3*48 +: 48] = 48'h0F0F0F_F0F0F0;
        @(negedge clock);
        chk("rmf_ready3", 64'(bus.req_ready), 64'(4'b1000));
        chk("rmf_busy", 64'(busy), 64'd0);
        for (int i = 0; i < N; i++) chk("rmf_cnt", 64'(dut.cnt_r[i]), 64'd0);
        tick();
        bus.req_valid = 4'b0000;
        repeat (12) tick();
        drain("rmf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
